pipelined_circular_shift_by_variable_amount: RTL and testbench

- Pipelined barrel rotator. Rotates an N-bit word left or right by a run-time amount in 0..N-1.
- Generalises the fixed-amount circular shifts of this chapter to a variable amount, with one register stage per shift-amount bit.
- Accepts one operand per cycle and sits directly downstream of the operand source, feeding the arithmetic/pipelining stages that consume res/res_vld.
- Uses the chapter's valid-only pipeline convention: no backpressure.

---
 rtl/pipelined_circular_shift_by_variable_amount_if.sv | 24 ++
 rtl/pipelined_circular_shift_by_variable_amount.sv | 78 +++++++
 tb/tb_pipelined_circular_shift_by_variable_amount.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_circular_shift_by_variable_amount_if.sv
// Operand/result bundle for the pipelined barrel rotator.
// The master drives operands and the slave returns rotated results, with no backpressure.
interface pipelined_circular_shift_by_variable_amount_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          arg_vld;
    logic [N-1:0]  a;
    logic [SW-1:0] amt;
    logic          dir;
    logic          res_vld;
    logic [N-1:0]  res;

    modport master (
        output arg_vld, a, amt, dir,
        input  res_vld, res
    );

    modport slave (
        input  arg_vld, a, amt, dir,
        output res_vld, res
    );
endinterface

// File: rtl/pipelined_circular_shift_by_variable_amount.sv
// Pipelined barrel rotator: stage k rotates by 2^k when amount bit k is set.
// The latency is one register per amount bit, and valid flows alongside the data with no stalls.
module pipelined_circular_shift_by_variable_amount #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    pipelined_circular_shift_by_variable_amount_if.slave bus
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
        $error("pipelined_circular_shift_by_variable_amount: N must be a power of two >= 2");
    end

    // Each stage consumes the lowest remaining amount bit, so the carried amount shrinks by one bit per stage.
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int R = 1 << k;

        logic [N-1:0]    data_in;
        logic [SW-1-k:0] amt_in;
        logic            dir_in;
        logic            vld_in;
        logic [N-1:0]    rot_l;
        logic [N-1:0]    rot_r;
        logic [N-1:0]    data_nxt;
        logic [N-1:0]    data_q;
        logic            vld_q;

        if (k == 0) begin : g_src
            assign data_in = bus.a;
            assign amt_in  = bus.amt;
            assign dir_in  = bus.dir;
            assign vld_in  = bus.arg_vld;
        end else begin : g_src
            assign data_in = g_stage[k-1].data_q;
            assign amt_in  = g_stage[k-1].g_carry.amt_q;
            assign dir_in  = g_stage[k-1].g_carry.dir_q;
            assign vld_in  = g_stage[k-1].vld_q;
        end

        assign rot_l    = {data_in[N-1-R:0], data_in[N-1:N-R]};
        assign rot_r    = {data_in[R-1:0], data_in[N-1:R]};
        assign data_nxt = amt_in[0] ? (dir_in ? rot_r : rot_l) : data_in;

        // Data only loads on valid slots, so bubbles leave res untouched after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q <= vld_in;
                if (vld_in) begin
                    data_q <= data_nxt;
                end
            end
        end

        if (k < SW - 1) begin : g_carry
            logic [SW-2-k:0] amt_q;
            logic            dir_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                    dir_q <= 1'b0;
                end else if (vld_in) begin
                    amt_q <= amt_in[SW-1-k:1];
                    dir_q <= dir_in;
                end
            end
        end
    end

    assign bus.res_vld = g_stage[SW-1].vld_q;
    assign bus.res     = g_stage[SW-1].data_q;

endmodule

// File: tb/tb_pipelined_circular_shift_by_variable_amount.sv
// Directed and random checks of the barrel rotator at N=8 and N=32.
// A bit-loop reference model and a delay line predict every output cycle.
module tb_pipelined_circular_shift_by_variable_amount;

    logic clk;
    logic rst;

    pipelined_circular_shift_by_variable_amount_if #(.N(8))  bus8 ();
    pipelined_circular_shift_by_variable_amount_if #(.N(32)) bus32 ();

    pipelined_circular_shift_by_variable_amount #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    pipelined_circular_shift_by_variable_amount #(.N(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rcv8 = 0;
    int rcv32 = 0;
    int exp8 = 0;
    int exp32 = 0;
    bit chk_zero = 1'b0;

    logic        m8_vld  [3];
    logic [7:0]  m8_res  [3];
    logic        m32_vld [5];
    logic [31:0] m32_res [5];
    logic [7:0]  hand_q [$];

    function automatic logic [31:0] rotRef(input logic [31:0] a, input int n, input int s, input logic d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (!d) r[(i + s) % n] = a[i];
            else    r[(i + n - s) % n] = a[i];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [2:0] amt, input logic d);
        bus8.arg_vld = v;
        bus8.a       = a;
        bus8.amt     = amt;
        bus8.dir     = d;
    endtask

    // One clock: advance the reference delay lines, then compare both DUTs just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m8_vld[i] = 1'b0; m8_res[i] = '0; end
            for (int i = 0; i < 5; i++) begin m32_vld[i] = 1'b0; m32_res[i] = '0; end
        end else begin
            for (int i = 2; i > 0; i--) begin m8_vld[i] = m8_vld[i-1]; m8_res[i] = m8_res[i-1]; end
            m8_vld[0] = bus8.arg_vld;
            m8_res[0] = 8'(rotRef(32'(bus8.a), 8, int'(bus8.amt), bus8.dir));
            for (int i = 4; i > 0; i--) begin m32_vld[i] = m32_vld[i-1]; m32_res[i] = m32_res[i-1]; end
            m32_vld[0] = bus32.arg_vld;
            m32_res[0] = rotRef(bus32.a, 32, int'(bus32.amt), bus32.dir);
        end
        #1;
        exp8  += int'(m8_vld[2]);
        exp32 += int'(m32_vld[4]);
        checkOutput("vld8", 32'(bus8.res_vld), 32'(m8_vld[2]));
        if (m8_vld[2]) checkOutput("res8", 32'(bus8.res), 32'(m8_res[2]));
        checkOutput("vld32", 32'(bus32.res_vld), 32'(m32_vld[4]));
        if (m32_vld[4]) checkOutput("res32", bus32.res, m32_res[4]);
        if (chk_zero) checkOutput("rst_res8", 32'(bus8.res), 32'h0);
        if (bus8.res_vld === 1'b1) begin
            rcv8++;
            if (hand_q.size() > 0) checkOutput("hand8", 32'(bus8.res), 32'(hand_q.pop_front()));
        end
        if (bus32.res_vld === 1'b1) rcv32++;
    endtask

    task automatic idle(input int cycles);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    task automatic singleOp(input logic [7:0] a, input logic [2:0] amt, input logic d, input logic [7:0] exp);
        hand_q.push_back(exp);
        applyStimulus(1'b1, a, amt, d);
        stepCycle();
        idle(4);
    endtask

    logic [7:0] stream_exp [8];
    logic       bub_vld    [5];
    logic [7:0] bub_a      [5];
    logic [2:0] bub_amt    [5];
    logic       bub_dir    [5];
    logic [7:0] bub_exp    [5];
    int         before_rst;

    initial begin
        stream_exp = '{8'h81, 8'hC0, 8'h06, 8'h30, 8'h18, 8'h0C, 8'h60, 8'h03};
        bub_vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bub_a   = '{8'h3C, 8'hFF, 8'hC3, 8'h96, 8'hFF};
        bub_amt = '{3'd2, 3'd5, 3'd4, 3'd1, 3'd6};
        bub_dir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bub_exp = '{8'hF0, 8'h00, 8'h3C, 8'h4B, 8'h00};
        for (int i = 0; i < 3; i++) begin m8_vld[i] = 1'b0; m8_res[i] = '0; end
        for (int i = 0; i < 5; i++) begin m32_vld[i] = 1'b0; m32_res[i] = '0; end

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        bus32.arg_vld = 1'b0;
        bus32.a       = '0;
        bus32.amt     = '0;
        bus32.dir     = 1'b0;

        chk_zero = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        idle(3);
        chk_zero = 1'b0;

        singleOp(8'hA3, 3'd3, 1'b0, 8'h1D);
        singleOp(8'hA3, 3'd3, 1'b1, 8'h74);
        singleOp(8'h01, 3'd7, 1'b0, 8'h80);
        singleOp(8'h01, 3'd7, 1'b1, 8'h02);
        singleOp(8'h5C, 3'd0, 1'b0, 8'h5C);
        singleOp(8'h5C, 3'd0, 1'b1, 8'h5C);
        singleOp(8'hFF, 3'd5, 1'b1, 8'hFF);
        singleOp(8'h00, 3'd6, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            hand_q.push_back(stream_exp[i]);
            applyStimulus(1'b1, 8'h81, 3'(i), 1'(i % 2));
            stepCycle();
        end
        idle(4);

        for (int i = 0; i < 5; i++) begin
            if (bub_vld[i]) hand_q.push_back(bub_exp[i]);
            applyStimulus(bub_vld[i], bub_a[i], bub_amt[i], bub_dir[i]);
            stepCycle();
        end
        idle(4);

        // Two operands in flight, then a reset that also carries a third operand: none may emerge.
        before_rst = rcv8;
        applyStimulus(1'b1, 8'h12, 3'd1, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h34, 3'd2, 1'b1);
        stepCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 8'h56, 3'd3, 1'b0);
        stepCycle();
        rst = 1'b0;
        idle(5);
        checkOutput("flush8", 32'(rcv8), 32'(before_rst));

        singleOp(8'hA3, 3'd3, 1'b0, 8'h1D);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            bus32.arg_vld = 1'($urandom_range(0, 1));
            bus32.a       = $urandom;
            bus32.amt     = 5'($urandom_range(0, 31));
            bus32.dir     = 1'($urandom_range(0, 1));
            stepCycle();
        end
        bus32.arg_vld = 1'b0;
        idle(6);

        checkOutput("cnt8", 32'(rcv8), 32'(exp8));
        checkOutput("cnt32", 32'(rcv32), 32'(exp32));
        checkOutput("hand_left", 32'(hand_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
